adler32: RTL and testbench
==========================

Name: adler32

Overview:
- Streaming Adler-32 checksum engine (RFC 1950) for the zlib wrapper of the PNG encoder.
- Consumes 32-bit words, each carrying 4 bytes, most-significant byte first.
- Outputs the running checksum {B[15:0], A[15:0]} after every word, and flags the final checksum of a stream.

Parameters:
- DATA_WD, 32, input/output word width; only 32 is supported.
- MOD (localparam), 65521, Adler modulus.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  reset, synchronous, active-high: rstn=1 at a rising edge resets the block.
- start_i  input  1  one-cycle pulse; begins a new stream (A=1, B=0).
- val_i  input  1  dat_i is valid this cycle.
- dat_i  input  32  4 data bytes, byte0=dat_i[31:24] … byte3=dat_i[7:0].
- lst_i  input  1  qualifies val_i; this word is the last of the stream.
- done_o  output  1  one-cycle pulse; dat_o holds the final checksum.
- val_o  output  1  one-cycle pulse; dat_o updated with the running checksum.
- dat_o  output  32  {B,A} checksum.

Behaviour:
- Reset values:
  - A=1, B=0, dat_o=0x00000001.
  - val_o=0, done_o=0.
  - FSM in IDLE.
- FSM:
  - IDLE: start_i → RUN.
  - RUN: accepted word with lst_i=1 → IDLE.
  - start_i in RUN restarts the stream: A=1, B=0, stays in RUN.
- Word acceptance:
  - A word is accepted when val_i=1 and (state==RUN or start_i=1).
  - val_i in IDLE without start_i is ignored: no output pulse, no state change.
- Start and data in the same cycle: the state is initialised first, then the word is processed from A=1, B=0.
- Per accepted word, in one cycle, for bytes byte0..byte3 in order:
  - A = (A + byte) mod 65521.
  - B = (B + A_new) mod 65521.
- Modulo reduction:
  - Each stage reduces with a single conditional subtract of 65521. This is valid because the operands are < 65521 + 255 and < 2*65521 respectively.
  - Stage sums are 17 bits wide.
  - A and B never exceed 65520.
- Latency: 1 cycle.
  - At the edge after acceptance, dat_o = {B,A} (registered) and val_o = 1 for one cycle.
  - done_o = 1 in the same cycle as val_o, for the lst_i word only.
- Throughput: one word per cycle; back-to-back val_i is allowed.
- dat_o holds its value until the next accepted word or reset.
  - start_i alone does not change dat_o.
- lst_i with val_i=0 is ignored.
- No partial last word: every stream is a whole number of 4-byte words. Byte-level lengths are handled upstream.
- Reset mid-stream: discards the accumulation and returns to IDLE. A pending output pulse is cleared.

Decomposition:
- Shared package: ADLER_MOD=65521, ADLER_INIT=32'h0000_0001, DATA_WD.
- One sub-module, adler32_byte_step: combinational single-byte update with mod reduction.
  - Inputs: A, B, byte. Outputs: A', B'.
  - Instantiated 4 times in a chain.
- Top level holds the FSM and registers.

Test Plan:
1. Reset held 5 cycles → dat_o=0x00000001, val_o=0, done_o=0 throughout.
2. start_i pulse, then dat_i=0x04090409 with val_i=1 and lst_i=1 for one cycle → next cycle val_o=1, done_o=1, dat_o=0x0040001B.
   - Per-byte intermediates: 0x00050005, 0x0013000E, 0x00250012, 0x0040001B.
3. start_i, then 0x04090409 (lst_i=0) followed by 0x04090409 (lst_i=1), back-to-back → cycle 1: val_o=1, done_o=0, dat_o=0x0040001B; cycle 2: val_o=1, done_o=1, dat_o=0x00E80035.
4. start_i and val_i same cycle, dat_i=0x61626364 ("abcd"), lst_i=1 → next cycle done_o=1, dat_o=0x03D8018B.
5. Modulo wrap: start_i, 65 words of 0xFFFFFFFF, last with lst_i=1 → final dat_o=0x0E36030C.
   - A and B are never ≥ 0xFFF1 on any val_o cycle.
   - Compare every val_o cycle against a software model.
6. Guard cases:
   - val_i=1 with 0x04090409 while IDLE (after the done of test 2) → no val_o, dat_o stays 0x0040001B.
   - rstn=1 mid-stream → dat_o=0x00000001, IDLE.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared constants and types for the Adler-32 checksum engine.
package adler32_pkg;

    localparam int unsigned DATA_WD    = 32;
    localparam int unsigned ADLER_WD   = 16;
    localparam int unsigned SUM_WD     = ADLER_WD + 1;
    localparam int unsigned BYTE_WD    = 8;
    localparam int unsigned ADLER_MOD  = 65521;
    localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/adler32_byte_step.sv
// Combinational single-byte Adler-32 update with modulo reduction.
// Ports:
//   a, b            current running sums (always < 65521)
//   data_byte       byte to fold in
//   a_next_c        (a + data_byte) mod 65521
//   b_next_c        (b + a_next_c) mod 65521
module adler32_byte_step
    import adler32_pkg::*;
(
    input  logic [ADLER_WD-1:0] a,
    input  logic [ADLER_WD-1:0] b,
    input  logic [BYTE_WD-1:0]  data_byte,
    output logic [ADLER_WD-1:0] a_next_c,
    output logic [ADLER_WD-1:0] b_next_c
);

    logic [SUM_WD-1:0] a_sum;
    logic [SUM_WD-1:0] b_sum;

    // Both sums stay below 2*MOD, so one conditional subtract fully reduces them.
    always_comb begin
        a_sum    = SUM_WD'(a) + SUM_WD'(data_byte);
        a_next_c = (a_sum >= SUM_WD'(ADLER_MOD)) ? ADLER_WD'(a_sum - SUM_WD'(ADLER_MOD))
                                                 : a_sum[ADLER_WD-1:0];
        b_sum    = SUM_WD'(b) + SUM_WD'(a_next_c);
        b_next_c = (b_sum >= SUM_WD'(ADLER_MOD)) ? ADLER_WD'(b_sum - SUM_WD'(ADLER_MOD))
                                                 : b_sum[ADLER_WD-1:0];
    end

endmodule

// File: rtl/adler32.sv
// Streaming Adler-32 checksum engine: one 32-bit word (4 bytes, MSB first) per cycle.
// Ports:
//   clk       system clock
//   rstn      synchronous reset, active-high
//   start_i   begin a new stream (A=1, B=0)
//   val_i     dat_i valid
//   dat_i     4 data bytes, byte0 = dat_i[31:24]
//   lst_i     with val_i: last word of the stream
//   done_o    pulse: dat_o is the final checksum
//   val_o     pulse: dat_o updated with running checksum
//   dat_o     {B, A}
module adler32 #(
    parameter int unsigned DATA_WD = 32     // only 32 supported
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    output logic               done_o,
    output logic               val_o,
    output logic [DATA_WD-1:0] dat_o
);

    import adler32_pkg::*;

    localparam int unsigned N_BYTES = DATA_WD / BYTE_WD;

    state_t              state_q;
    state_t              state_d;
    logic [ADLER_WD-1:0] a_q;
    logic [ADLER_WD-1:0] b_q;
    logic [ADLER_WD-1:0] a_d;
    logic [ADLER_WD-1:0] b_d;
    logic [DATA_WD-1:0]  dat_d;
    logic                val_d;
    logic                done_d;
    logic                accept_c;

    logic [ADLER_WD-1:0] a_chain [N_BYTES+1];
    logic [ADLER_WD-1:0] b_chain [N_BYTES+1];

    // A start in the same cycle as data seeds the chain with the initial sums.
    assign a_chain[0] = start_i ? ADLER_INIT[ADLER_WD-1:0] : a_q;
    assign b_chain[0] = start_i ? ADLER_INIT[DATA_WD-1:ADLER_WD] : b_q;

    // Byte0 (most significant) is folded in first.
    for (genvar i = 0; i < N_BYTES; i++) begin : g_step
        adler32_byte_step u_step (
            .a         (a_chain[i]),
            .b         (b_chain[i]),
            .data_byte (dat_i[DATA_WD-1-BYTE_WD*i -: BYTE_WD]),
            .a_next_c  (a_chain[i+1]),
            .b_next_c  (b_chain[i+1])
        );
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dat_d    = dat_o;
        val_d    = 1'b0;
        done_d   = 1'b0;
        accept_c = val_i && ((state_q == ST_RUN) || start_i);

        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase

        // start alone reinitialises the sums but leaves dat_o untouched.
        if (start_i) begin
            a_d = a_chain[0];
            b_d = b_chain[0];
        end

        if (accept_c) begin
            a_d    = a_chain[N_BYTES];
            b_d    = b_chain[N_BYTES];
            dat_d  = DATA_WD'({b_chain[N_BYTES], a_chain[N_BYTES]});
            val_d  = 1'b1;
            done_d = lst_i;
            if (lst_i) state_d = ST_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= ST_IDLE;
            a_q     <= ADLER_INIT[ADLER_WD-1:0];
            b_q     <= ADLER_INIT[DATA_WD-1:ADLER_WD];
            dat_o   <= DATA_WD'(ADLER_INIT);
            val_o   <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dat_o   <= dat_d;
            val_o   <= val_d;
            done_o  <= done_d;
        end
    end

endmodule

// File: tb/tb_adler32.sv
// Self-checking bench for adler32 with a byte-level reference model.
module tb_adler32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic        val_i = 1'b0;
    logic        lst_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic        done_o;
    logic        val_o;
    logic [31:0] dat_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_out;

    localparam logic [31:0] W0409 = 32'h0409_0409;

    always #5 clk = ~clk;

    adler32 #(.DATA_WD(32)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (start_i),
        .val_i   (val_i),
        .dat_i   (dat_i),
        .lst_i   (lst_i),
        .done_o  (done_o),
        .val_o   (val_o),
        .dat_o   (dat_o)
    );

    // Reference: fold bytes MSB-first using plain modular arithmetic.
    function automatic logic [31:0] model_word(input logic [31:0] sum, input logic [31:0] word);
        int unsigned a;
        int unsigned b;
        a = 32'(sum[15:0]);
        b = 32'(sum[31:16]);
        for (int i = 3; i >= 0; i--) begin
            a = (a + 32'(word[8*i +: 8])) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic cycle(input logic st, input logic v, input logic [31:0] d, input logic l);
        start_i = st;
        val_i   = v;
        dat_i   = d;
        lst_i   = l;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        val_i   = 1'b0;
        lst_i   = 1'b0;
        dat_i   = $urandom;
    endtask

    task automatic test_reset;
        rstn  = 1'b1;
        val_i = 1'b1;
        dat_i = W0409;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (dat_o !== 32'h0000_0001 || val_o !== 1'b0 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: dat_o=%h val_o=%b done_o=%b, required 00000001/0/0",
                         i, dat_o, val_o, done_o);
            end
        end
        val_i = 1'b0;
        rstn  = 1'b0;
        exp_out = 32'h0000_0001;
    endtask

    task automatic test_single;
        cycle(1'b1, 1'b0, W0409, 1'b0);
        n_checks++;
        if (val_o !== 1'b0 || dat_o !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL single_start: val_o=%b dat_o=%h, required 0/00000001", val_o, dat_o);
        end
        cycle(1'b0, 1'b1, W0409, 1'b1);
        n_checks++;
        if (val_o !== 1'b1 || done_o !== 1'b1 || dat_o !== 32'h0040_001B) begin
            n_fail++;
            $display("FAIL single_word: val_o=%b done_o=%b dat_o=%h, required 1/1/0040001b",
                     val_o, done_o, dat_o);
        end
        cycle(1'b0, 1'b0, W0409, 1'b0);
        n_checks++;
        if (val_o !== 1'b0 || done_o !== 1'b0 || dat_o !== 32'h0040_001B) begin
            n_fail++;
            $display("FAIL single_pulse: val_o=%b done_o=%b dat_o=%h, required 0/0/0040001b",
                     val_o, done_o, dat_o);
        end
        exp_out = 32'h0040_001B;
    endtask

    task automatic test_idle_guard;
        cycle(1'b0, 1'b1, W0409, 1'b0);
        n_checks++;
        if (val_o !== 1'b0 || done_o !== 1'b0 || dat_o !== 32'h0040_001B) begin
            n_fail++;
            $display("FAIL idle_guard: val_o=%b done_o=%b dat_o=%h, required 0/0/0040001b",
                     val_o, done_o, dat_o);
        end
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, W0409, 1'b0);
        n_checks++;
        if (val_o !== 1'b1 || done_o !== 1'b0 || dat_o !== 32'h0040_001B) begin
            n_fail++;
            $display("FAIL b2b_first: val_o=%b done_o=%b dat_o=%h, required 1/0/0040001b",
                     val_o, done_o, dat_o);
        end
        cycle(1'b0, 1'b1, W0409, 1'b1);
        n_checks++;
        if (val_o !== 1'b1 || done_o !== 1'b1 || dat_o !== 32'h00E8_0035) begin
            n_fail++;
            $display("FAIL b2b_second: val_o=%b done_o=%b dat_o=%h, required 1/1/00e80035",
                     val_o, done_o, dat_o);
        end
    endtask

    task automatic test_start_with_data;
        cycle(1'b1, 1'b1, 32'h6162_6364, 1'b1);
        n_checks++;
        if (val_o !== 1'b1 || done_o !== 1'b1 || dat_o !== 32'h03D8_018B) begin
            n_fail++;
            $display("FAIL start_data: val_o=%b done_o=%b dat_o=%h, required 1/1/03d8018b",
                     val_o, done_o, dat_o);
        end
        // The stream ended, so a bare word must now be ignored.
        cycle(1'b0, 1'b1, W0409, 1'b1);
        n_checks++;
        if (val_o !== 1'b0 || dat_o !== 32'h03D8_018B) begin
            n_fail++;
            $display("FAIL start_data_idle: val_o=%b dat_o=%h, required 0/03d8018b", val_o, dat_o);
        end
        exp_out = 32'h03D8_018B;
    endtask

    task automatic test_modulo_wrap;
        logic [31:0] sum;
        sum = 32'h0000_0001;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 65; k++) begin
            cycle(1'b0, 1'b1, 32'hFFFF_FFFF, k == 64);
            sum = model_word(sum, 32'hFFFF_FFFF);
            n_checks++;
            if (val_o !== 1'b1 || done_o !== (k == 64) || dat_o !== sum
                || dat_o[15:0] >= 16'hFFF1 || dat_o[31:16] >= 16'hFFF1) begin
                n_fail++;
                $display("FAIL wrap_word%0d: val_o=%b done_o=%b dat_o=%h, required 1/%b/%h",
                         k, val_o, done_o, dat_o, k == 64, sum);
            end
        end
        n_checks++;
        if (dat_o !== 32'h0E36_030C) begin
            n_fail++;
            $display("FAIL wrap_final: dat_o=%h, required 0e36030c", dat_o);
        end
        exp_out = 32'h0E36_030C;
    endtask

    task automatic test_restart_in_run;
        logic [31:0] sum;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, W0409, 1'b0);
        cycle(1'b0, 1'b0, W0409, 1'b1);
        n_checks++;
        if (val_o !== 1'b0 || done_o !== 1'b0 || dat_o !== 32'h0040_001B) begin
            n_fail++;
            $display("FAIL lst_no_val: val_o=%b done_o=%b dat_o=%h, required 0/0/0040001b",
                     val_o, done_o, dat_o);
        end
        cycle(1'b1, 1'b1, 32'h6162_6364, 1'b0);
        n_checks++;
        if (val_o !== 1'b1 || done_o !== 1'b0 || dat_o !== 32'h03D8_018B) begin
            n_fail++;
            $display("FAIL restart: val_o=%b done_o=%b dat_o=%h, required 1/0/03d8018b",
                     val_o, done_o, dat_o);
        end
        sum = model_word(32'h03D8_018B, W0409);
        cycle(1'b0, 1'b1, W0409, 1'b1);
        n_checks++;
        if (val_o !== 1'b1 || done_o !== 1'b1 || dat_o !== sum) begin
            n_fail++;
            $display("FAIL restart_tail: val_o=%b done_o=%b dat_o=%h, required 1/1/%h",
                     val_o, done_o, dat_o, sum);
        end
        exp_out = sum;
    endtask

    task automatic test_random;
        logic [31:0] sum;
        logic [31:0] w;
        int          len;
        bit          same;
        for (int s = 0; s < 8; s++) begin
            len  = $urandom_range(1, 8);
            same = 1'($urandom_range(0, 1));
            sum  = 32'h0000_0001;
            if (!same) begin
                cycle(1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)));
                n_checks++;
                if (val_o !== 1'b0 || dat_o !== exp_out) begin
                    n_fail++;
                    $display("FAIL rnd_start s%0d: val_o=%b dat_o=%h, required 0/%h",
                             s, val_o, dat_o, exp_out);
                end
            end
            for (int k = 0; k < len; k++) begin
                if (!(same && k == 0) && $urandom_range(0, 2) == 0) begin
                    cycle(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)));
                    n_checks++;
                    if (val_o !== 1'b0 || done_o !== 1'b0 || dat_o !== exp_out) begin
                        n_fail++;
                        $display("FAIL rnd_gap s%0d k%0d: val_o=%b dat_o=%h, required 0/%h",
                                 s, k, val_o, dat_o, exp_out);
                    end
                end
                w = $urandom;
                cycle(same && k == 0, 1'b1, w, k == len - 1);
                sum     = model_word(sum, w);
                exp_out = sum;
                n_checks++;
                if (val_o !== 1'b1 || done_o !== (k == len - 1) || dat_o !== sum) begin
                    n_fail++;
                    $display("FAIL rnd_word s%0d k%0d: val_o=%b done_o=%b dat_o=%h, required 1/%b/%h",
                             s, k, val_o, done_o, dat_o, k == len - 1, sum);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, W0409, 1'b0);
        // Word presented in the reset cycle must not produce a pulse.
        rstn  = 1'b1;
        val_i = 1'b1;
        dat_i = W0409;
        @(posedge clk);
        #1;
        rstn  = 1'b0;
        val_i = 1'b0;
        n_checks++;
        if (val_o !== 1'b0 || done_o !== 1'b0 || dat_o !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL mid_reset: val_o=%b done_o=%b dat_o=%h, required 0/0/00000001",
                     val_o, done_o, dat_o);
        end
        cycle(1'b0, 1'b1, W0409, 1'b1);
        n_checks++;
        if (val_o !== 1'b0 || dat_o !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL mid_reset_idle: val_o=%b dat_o=%h, required 0/00000001", val_o, dat_o);
        end
    endtask

    initial begin
        exp_out = 32'h0000_0001;
        test_reset;
        test_single;
        test_idle_guard;
        test_back_to_back;
        test_start_with_data;
        test_modulo_wrap;
        test_restart_in_run;
        test_random;
        test_reset_mid_stream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
